// File: rtl/morse_decoder_if.sv
// Slot-stream input and decoded-letter output bundle for the Morse letter decoder.
interface morse_decoder_if;
   logic       DotDashIn;
   logic       NewBitIn;
   logic [2:0] LetterOut;
   logic       LetterValid;
   logic       DecodeError;

   modport master (
      output DotDashIn, NewBitIn,
      input  LetterOut, LetterValid, DecodeError
   );

   modport slave (
      input  DotDashIn, NewBitIn,
      output LetterOut, LetterValid, DecodeError
   );
endinterface

// File: rtl/morse_decoder.sv
// Recovers letters A..H from a strobed dot/dash slot stream.
// state | meaning
// IDLE  | between letters, pad zeros ignored
// MARK  | counting a run of tone slots
// SPACE | counting silence after an element
// DRAIN | bad symbol reported, waiting for a letter gap
module morse_decoder #(
   parameter int DASH_LEN = 3,
   parameter int GAP_LEN  = 3
) (
   input logic            ClockIn,
   input logic            Reset,
   morse_decoder_if.slave bus
);
   localparam int SW = $clog2(GAP_LEN + 1);

   typedef enum logic [1:0] {IDLE, MARK, SPACE, DRAIN} state_t;

   state_t        r_state;
   logic [2:0]    r_mark_cnt;
   logic [SW-1:0] r_space_cnt;
   logic [2:0]    r_elem_cnt;
   logic [3:0]    r_pattern;
   logic [2:0]    r_letter;
   logic          r_valid;
   logic          r_error;

   logic          w_is_dot;
   logic          w_is_dash;
   logic [2:0]    w_mark_inc;
   logic [SW-1:0] w_space_inc;
   logic          w_gap_done;
   logic          w_hit;
   logic [2:0]    w_code;

   assign w_is_dot    = (r_mark_cnt == 3'd1);
   assign w_is_dash   = (r_mark_cnt == 3'(DASH_LEN));
   assign w_mark_inc  = (r_mark_cnt == 3'd7) ? 3'd7 : r_mark_cnt + 3'd1;
   assign w_space_inc = (r_space_cnt == SW'(GAP_LEN)) ? r_space_cnt : r_space_cnt + SW'(1);
   assign w_gap_done  = (w_space_inc == SW'(GAP_LEN));

   // Pattern holds elements oldest-first toward the MSB; unused upper bits stay zero.
   always_comb begin
      w_hit  = 1'b1;
      w_code = 3'd0;
      case ({r_elem_cnt, r_pattern})
         {3'd2, 4'b0001}: w_code = 3'd0;
         {3'd4, 4'b1000}: w_code = 3'd1;
         {3'd4, 4'b1010}: w_code = 3'd2;
         {3'd3, 4'b0100}: w_code = 3'd3;
         {3'd1, 4'b0000}: w_code = 3'd4;
         {3'd4, 4'b0010}: w_code = 3'd5;
         {3'd3, 4'b0110}: w_code = 3'd6;
         {3'd4, 4'b0000}: w_code = 3'd7;
         default:         w_hit  = 1'b0;
      endcase
   end

   always_ff @(posedge ClockIn or negedge Reset) begin
      if (!Reset) begin
         r_state     <= IDLE;
         r_mark_cnt  <= 3'd0;
         r_space_cnt <= '0;
         r_elem_cnt  <= 3'd0;
         r_pattern   <= 4'd0;
         r_letter    <= 3'd0;
         r_valid     <= 1'b0;
         r_error     <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         r_error <= 1'b0;
         if (bus.NewBitIn) begin
            unique case (r_state)
               IDLE: begin
                  if (bus.DotDashIn) begin
                     r_state    <= MARK;
                     r_mark_cnt <= 3'd1;
                     r_elem_cnt <= 3'd0;
                     r_pattern  <= 4'd0;
                  end
               end
               MARK: begin
                  if (bus.DotDashIn) begin
                     r_mark_cnt <= w_mark_inc;
                  end else if ((!w_is_dot && !w_is_dash) || r_elem_cnt == 3'd4) begin
                     // The terminating zero already counts toward the drain gap.
                     r_error     <= 1'b1;
                     r_state     <= DRAIN;
                     r_space_cnt <= SW'(1);
                  end else begin
                     r_pattern   <= {r_pattern[2:0], w_is_dash};
                     r_elem_cnt  <= r_elem_cnt + 3'd1;
                     r_space_cnt <= SW'(1);
                     r_state     <= SPACE;
                  end
               end
               SPACE: begin
                  if (!bus.DotDashIn) begin
                     r_space_cnt <= w_space_inc;
                     if (w_gap_done) begin
                        r_state <= IDLE;
                        if (w_hit) begin
                           r_letter <= w_code;
                           r_valid  <= 1'b1;
                        end else begin
                           r_error <= 1'b1;
                        end
                     end
                  end else if (r_space_cnt == SW'(1)) begin
                     r_state    <= MARK;
                     r_mark_cnt <= 3'd1;
                  end else begin
                     r_error     <= 1'b1;
                     r_state     <= DRAIN;
                     r_space_cnt <= '0;
                  end
               end
               DRAIN: begin
                  if (bus.DotDashIn) begin
                     r_space_cnt <= '0;
                  end else if (w_gap_done) begin
                     r_state     <= IDLE;
                     r_space_cnt <= '0;
                  end else begin
                     r_space_cnt <= w_space_inc;
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign bus.LetterOut   = r_letter;
   assign bus.LetterValid = r_valid;
   assign bus.DecodeError = r_error;
endmodule

// File: tb/tb_morse_decoder.sv
// Scoreboard bench: symbols are built as element lists, outcomes predicted from Morse rules.
module tb_morse_decoder;
   localparam int DASH_LEN = 3;
   localparam int GAP_LEN  = 3;

   typedef struct {
      bit         is_err;
      logic [2:0] letter;
      int         slot;
   } exp_t;

   logic ClockIn = 1'b0;
   logic Reset   = 1'b0;
   morse_decoder_if bus ();

   morse_decoder #(.DASH_LEN(DASH_LEN), .GAP_LEN(GAP_LEN)) dut (
      .ClockIn (ClockIn),
      .Reset   (Reset),
      .bus     (bus.slave)
   );

   always #5 ClockIn = ~ClockIn;

   int         checks = 0;
   int         errors = 0;
   int         slot_no = 0;
   int         idle_max = 2;
   logic [2:0] cur_letter = 3'd0;
   exp_t       sb[$];
   int         sym_marks[$];
   int         sym_gaps[$];
   string      codes[8] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "...."};

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive_slot(input bit b);
      bus.DotDashIn = b;
      bus.NewBitIn  = 1'b1;
      slot_no++;
      @(negedge ClockIn);
      bus.NewBitIn = 1'b0;
      repeat ($urandom_range(0, idle_max)) begin
         bus.DotDashIn = 1'($urandom_range(0, 1));
         @(negedge ClockIn);
      end
   endtask

   task automatic load_letter(input int idx);
      string c;
      c = codes[idx];
      sym_marks.delete();
      sym_gaps.delete();
      for (int i = 0; i < c.len(); i++) begin
         sym_marks.push_back((c[i] == "-") ? DASH_LEN : 1);
         if (i > 0) sym_gaps.push_back(1);
      end
   endtask

   // Predict the outcome of the loaded symbol from element rules, then drive it.
   task automatic send_symbol(input int lead, input int trail);
      bit    bits[$];
      int    base, first0, err_slot;
      bit    err;
      string code;
      exp_t  e;
      int    hit;
      base = slot_no;
      err  = 1'b0;
      code = "";
      err_slot = 0;
      repeat (lead) bits.push_back(1'b0);
      for (int i = 0; i < sym_marks.size(); i++) begin
         if (!err && i > 0 && sym_gaps[i-1] > 1) begin
            err = 1'b1;
            err_slot = base + bits.size() + 1;
         end
         repeat (sym_marks[i]) bits.push_back(1'b1);
         if (!err) begin
            if ((sym_marks[i] != 1 && sym_marks[i] != DASH_LEN) || code.len() == 4) begin
               err = 1'b1;
               err_slot = base + bits.size() + 1;
            end else if (sym_marks[i] == 1) code = {code, "."};
            else code = {code, "-"};
         end
         if (i < sym_marks.size() - 1) repeat (sym_gaps[i]) bits.push_back(1'b0);
      end
      first0 = bits.size();
      repeat (trail) bits.push_back(1'b0);
      if (err) begin
         e.is_err = 1'b1;
         e.slot   = err_slot;
      end else begin
         hit = -1;
         for (int j = 0; j < 8; j++) if (codes[j] == code) hit = j;
         e.slot = base + first0 + GAP_LEN;
         if (hit >= 0) begin
            e.is_err   = 1'b0;
            cur_letter = 3'(hit);
         end else begin
            e.is_err = 1'b1;
         end
      end
      e.letter = cur_letter;
      sb.push_back(e);
      foreach (bits[k]) drive_slot(bits[k]);
   endtask

   task automatic check_cleared(input string tag);
      chk({tag, "_letter"}, int'(bus.LetterOut), 0);
      chk({tag, "_valid"}, int'(bus.LetterValid), 0);
      chk({tag, "_error"}, int'(bus.DecodeError), 0);
   endtask

   initial begin : monitor
      bit   prev;
      exp_t e;
      prev = 1'b0;
      forever begin
         @(posedge ClockIn);
         #1;
         if (Reset && (bus.LetterValid || bus.DecodeError)) begin
            if (bus.LetterValid && bus.DecodeError) chk("pulse_exclusive", 1, 0);
            if (prev) chk("pulse_back_to_back", 1, 0);
            if (sb.size() == 0) begin
               chk("unexpected_pulse_slot", slot_no, -1);
            end else begin
               e = sb.pop_front();
               chk("pulse_kind_err", int'(bus.DecodeError), int'(e.is_err));
               chk("pulse_slot", slot_no, e.slot);
               chk("letter_out", int'(bus.LetterOut), int'(e.letter));
            end
         end
         prev = Reset && (bus.LetterValid || bus.DecodeError);
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1);
   end

   initial begin : stim
      int lens[6] = '{1, 1, 3, 3, 2, 4};
      int n;
      bus.DotDashIn = 1'b0;
      bus.NewBitIn  = 1'b0;
      #1;
      check_cleared("reset");
      repeat (3) @(negedge ClockIn);
      Reset = 1'b1;
      @(negedge ClockIn);

      for (int l = 0; l < 8; l++) begin
         load_letter(l);
         send_symbol(0, GAP_LEN);
      end

      load_letter(4);
      send_symbol(0, GAP_LEN + 20);
      chk("tail_letter", int'(bus.LetterOut), 4);

      sym_marks = '{2};
      sym_gaps.delete();
      send_symbol(0, GAP_LEN);
      load_letter(3);
      send_symbol(0, GAP_LEN);

      sym_marks = '{DASH_LEN, DASH_LEN};
      sym_gaps  = '{1};
      send_symbol(0, GAP_LEN);

      sym_marks = '{1, 1, 1, 1, 1};
      sym_gaps  = '{1, 1, 1, 1};
      send_symbol(0, GAP_LEN);

      for (int i = 0; i < 50; i++) begin
         bus.DotDashIn = i[0];
         @(negedge ClockIn);
      end
      chk("gated_letter", int'(bus.LetterOut), 3);
      load_letter(2);
      send_symbol(1, GAP_LEN);

      drive_slot(1'b1); drive_slot(1'b1); drive_slot(1'b1);
      drive_slot(1'b0); drive_slot(1'b1);
      #2;
      Reset = 1'b0;
      #1;
      check_cleared("async_reset");
      cur_letter = 3'd0;
      repeat (2) @(negedge ClockIn);
      Reset = 1'b1;
      @(negedge ClockIn);
      load_letter(6);
      send_symbol(0, GAP_LEN);

      for (int s = 0; s < 60; s++) begin
         if ($urandom_range(0, 9) < 7) begin
            load_letter($urandom_range(0, 7));
         end else begin
            sym_marks.delete();
            sym_gaps.delete();
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
               sym_marks.push_back(lens[$urandom_range(0, 5)]);
               if (i > 0) sym_gaps.push_back(($urandom_range(0, 3) == 0) ? 2 : 1);
            end
         end
         send_symbol($urandom_range(0, 2), GAP_LEN + $urandom_range(0, 2));
      end

      repeat (10) @(negedge ClockIn);
      chk("scoreboard_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/morse_decoder.md
Name: morse_decoder

Overview:
- Receive-side counterpart of the lab-5 Morse letter transmitter. Consumes the serial dot/dash slot stream (one slot per NewBitIn strobe) and recovers the 3-bit letter code A..H.
- Sits after the transmitter's DotDashOut/NewBitOut pair, or after a debounced key input that has been re-timed to the same slot strobe.
- Reports each decoded letter with a one-cycle valid pulse. Flags malformed symbols with a one-cycle error pulse.

Parameters:
- DASH_LEN, 3, number of consecutive 1-slots that form a dash. A dot is exactly 1 slot.
- GAP_LEN, 3, number of consecutive 0-slots that terminate a letter. A gap of exactly 1 zero is an element gap.

Ports:
- ClockIn  input  1  system clock; all state updates on its rising edge.
- Reset  input  1  asynchronous, active-low reset. Reset=0 clears all state immediately, independent of ClockIn.
- DotDashIn  input  1  current slot value (1 = tone, 0 = silence). Sampled only when NewBitIn=1.
- NewBitIn  input  1  slot strobe, one ClockIn cycle wide per slot. Cycles with NewBitIn=0 change no state.
- LetterOut  output  3  last decoded letter (000=A … 111=H). Holds its value between decodes.
- LetterValid  output  1  one-cycle pulse when LetterOut has just been updated.
- DecodeError  output  1  one-cycle pulse when a malformed symbol is detected.

Behaviour:
- Reset values: LetterOut=000, LetterValid=0, DecodeError=0, state=IDLE, all counters and the pattern register cleared.
- Internal state:
  - markCnt: ones-run counter, 3 bits, saturates at 7.
  - spaceCnt: zeros-run counter, saturates at GAP_LEN.
  - elemCnt: 0..4.
  - pattern: 4 bits; each element shifts in at the LSB, dot=0, dash=1.
- FSM states: IDLE, MARK, SPACE, DRAIN. All transitions below occur only on edges where NewBitIn=1.
- IDLE:
  - DotDashIn=0: remain in IDLE. Leading and trailing pad zeros are ignored, so a repeating all-zero tail never re-fires LetterValid.
  - DotDashIn=1: go to MARK with markCnt=1, elemCnt=0, pattern=0.
- MARK:
  - DotDashIn=1: increment markCnt.
  - DotDashIn=0: classify the run. markCnt=1 is a dot; markCnt=DASH_LEN is a dash; any other length is an error and goes to DRAIN.
  - On a valid element with elemCnt already 4 (5th element): error, go to DRAIN.
  - Otherwise shift the element into pattern, increment elemCnt, set spaceCnt=1, go to SPACE.
- SPACE:
  - DotDashIn=0: increment spaceCnt. When spaceCnt reaches GAP_LEN, perform the letter lookup and go to IDLE.
  - DotDashIn=1 with spaceCnt=1: element gap; go to MARK with markCnt=1.
  - DotDashIn=1 with 1<spaceCnt<GAP_LEN: error, go to DRAIN.
- Letter lookup, as (elemCnt, pattern):
  - A (2, 01)
  - B (4, 1000)
  - C (4, 1010)
  - D (3, 100)
  - E (1, 0)
  - F (4, 0010)
  - G (3, 110)
  - H (4, 0000)
  - A match writes LetterOut and pulses LetterValid on the same edge.
  - Any other combination pulses DecodeError, leaves LetterOut unchanged, and returns to IDLE (no DRAIN).
- DRAIN:
  - Entered with DecodeError pulsed on the same edge (exactly one pulse per bad symbol).
  - Ignores all ones. Counts consecutive zeros, and a one resets that count.
  - After GAP_LEN consecutive zeros, go to IDLE with no further pulses.
- Latency: LetterValid/DecodeError rise on the ClockIn edge that samples the terminating slot, i.e. they are high during the following cycle. They are registered outputs and are never high for two consecutive cycles.
- LetterValid and DecodeError are mutually exclusive.
- Reset=0 mid-letter or mid-DRAIN aborts with no pulse. Decoding restarts at IDLE once Reset returns to 1.
- A NewBitIn strobe coincident with the reset deassertion edge is not required to be captured.

Test Plan:
- Full alphabet: drive each of the 8 transmitter slot patterns, each followed by ≥3 zero slots; A=1,0,1,1,1 then 000. Each letter must give exactly one LetterValid with LetterOut = 000…111 in order, and DecodeError stays 0.
- Idle tail: after decoding E (pattern 1 then 000), drive 20 more zero slots. LetterValid must pulse exactly once in total, and LetterOut must hold 100.
- Bad mark length: slots 1,1,0,0,0. DecodeError must pulse once at the first 0 and LetterValid stays 0. A following clean D (111,0,1,0,1,000) must give LetterOut=011.
- Unknown symbol and overflow: dash-dash (111 0 111 000) must pulse DecodeError once at the third trailing zero, with LetterOut unchanged. Five dots must pulse DecodeError at the 5th element's trailing 0, then DRAIN until 000.
- Gating: hold DotDashIn toggling every cycle with NewBitIn=0 for 50 cycles. There must be no pulses and no state change, and the next valid letter must decode normally.
- Async reset: assert Reset=0 mid-B (after 111 0 1) with no ClockIn edge. Outputs must clear immediately to LetterOut=000, LetterValid=0, DecodeError=0. After release, G (111 0 111 0 1 000) must decode to 110 with no error.
